// File: rtl/store_buffer.sv
// Posted-write store buffer between the pipeline MEM stage and a single-port data memory.
// In-order FIFO drain, store-to-load forwarding, and stalls for loads that partially overlap a pending store.
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_WIDTH-1:0]    st_addr,
    input  logic [BYTE_SIZE*8-1:0]   st_data,
    input  logic                     ld_valid,
    input  logic [ADDR_WIDTH-1:0]    ld_addr,
    output logic                     ld_ready,
    output logic [BYTE_SIZE*8-1:0]   ld_data,
    output logic                     sb_empty,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [BYTE_SIZE*8-1:0]   mem_wd,
    input  logic [BYTE_SIZE*8-1:0]   mem_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = BYTE_SIZE * 8;
    localparam logic [PW:0]            FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  BS_A     = ADDR_WIDTH'(BYTE_SIZE);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DW-1:0]         data_q [DEPTH];
    logic [DW-1:0]         data_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [PW:0]           count_q, count_d;

    logic                  full, empty, enq, drain;
    logic                  any_exact, any_partial;
    logic [DW-1:0]         fwd_data;
    logic [PW-1:0]         idx;
    logic [ADDR_WIDTH-1:0] diff_fwd, diff_bwd;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign st_ready = !full;
    assign sb_empty = empty;
    assign enq      = st_valid && st_ready;

    // Walk entries oldest to youngest so the last exact hit wins.
    always_comb begin
        any_exact   = 1'b0;
        any_partial = 1'b0;
        fwd_data    = '0;
        idx         = '0;
        diff_fwd    = '0;
        diff_bwd    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx      = head_q + PW'(k);
            diff_fwd = ld_addr - addr_q[idx];
            diff_bwd = addr_q[idx] - ld_addr;
            if (valid_q[idx]) begin
                if (diff_fwd == '0) begin
                    any_exact = 1'b1;
                    fwd_data  = data_q[idx];
                end else if (diff_fwd < BS_A || diff_bwd < BS_A) begin
                    any_partial = 1'b1;
                end
            end
        end
    end

    // Port arbitration: the memory port goes to the load only when nothing pending touches its bytes.
    always_comb begin
        drain    = 1'b0;
        ld_ready = 1'b0;
        ld_data  = '0;
        if (ld_valid && (full || any_partial)) begin
            drain = 1'b1;
        end else if (ld_valid && any_exact) begin
            ld_ready = 1'b1;
            ld_data  = fwd_data;
            drain    = 1'b1;
        end else if (ld_valid) begin
            ld_ready = 1'b1;
            ld_data  = mem_rd;
        end else begin
            drain = !empty;
        end
    end

    always_comb begin
        mem_we   = drain;
        mem_addr = drain ? addr_q[head_q] : ld_addr;
        mem_wd   = drain ? data_q[head_q] : '0;
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            addr_d[tail_q]  = st_addr;
            data_d[tail_q]  = st_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        case ({enq, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Reset discards pending stores; nothing reaches memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: byte memory behind the port, a queue-based reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_addr, ld_data;
    logic        sb_empty, mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    int vectors = 0;
    int errors  = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic        exp_drain_r, exp_enq_r;
    logic [31:0] enq_addr_r, enq_data_r;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .BYTE_SIZE(4), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready), .ld_data(ld_data),
        .sb_empty(sb_empty),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    endfunction

    // Data memory with combinational read, 256-byte window.
    always_comb mem_rd = {mem[mem_addr[7:0] + 8'd3], mem[mem_addr[7:0] + 8'd2],
                          mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]} = 32'h5A5A1234;
        forever begin
            @(posedge clk);
            if (mem_we)
                for (int k = 0; k < 4; k++) mem[mem_addr[7:0] + 8'(k)] <= mem_wd[8*k +: 8];
        end
    end

    // Reference model state update: pending stores as a program-order queue.
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        {ref_mem[8'h83], ref_mem[8'h82], ref_mem[8'h81], ref_mem[8'h80]} = 32'h5A5A1234;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                q_addr.delete();
                q_data.delete();
            end else begin
                if (exp_drain_r && q_addr.size() > 0) begin
                    for (int k = 0; k < 4; k++) ref_mem[q_addr[0][7:0] + 8'(k)] = q_data[0][8*k +: 8];
                    void'(q_addr.pop_front());
                    void'(q_data.pop_front());
                end
                if (exp_enq_r) begin
                    q_addr.push_back(enq_addr_r);
                    q_data.push_back(enq_data_r);
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        int          n;
        logic        m_full, m_empty, m_exact, m_partial, e_drain, e_ldr;
        logic [31:0] fwd, e_ldd, d1, d2;
        exp_drain_r = 1'b0;
        exp_enq_r   = 1'b0;
        enq_addr_r  = '0;
        enq_data_r  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_drain_r = 1'b0;
                exp_enq_r   = 1'b0;
            end else begin
                n         = q_addr.size();
                m_full    = (n == 4);
                m_empty   = (n == 0);
                m_exact   = 1'b0;
                m_partial = 1'b0;
                fwd       = '0;
                for (int i = 0; i < n; i++) begin
                    d1 = ld_addr - q_addr[i];
                    d2 = q_addr[i] - ld_addr;
                    if (ld_addr == q_addr[i]) begin
                        m_exact = 1'b1;
                        fwd     = q_data[i];
                    end else if (d1 < 32'd4 || d2 < 32'd4) begin
                        m_partial = 1'b1;
                    end
                end
                e_drain = 1'b0;
                e_ldr   = 1'b0;
                e_ldd   = '0;
                if (ld_valid && (m_full || m_partial)) e_drain = 1'b1;
                else if (ld_valid && m_exact) begin
                    e_ldr = 1'b1; e_ldd = fwd; e_drain = 1'b1;
                end else if (ld_valid) begin
                    e_ldr = 1'b1; e_ldd = ref_word(ld_addr[7:0]);
                end else e_drain = !m_empty;

                chk("st_ready", {31'b0, st_ready}, {31'b0, !m_full});
                chk("sb_empty", {31'b0, sb_empty}, {31'b0, m_empty});
                chk("mem_we",   {31'b0, mem_we},   {31'b0, e_drain});
                chk("ld_ready", {31'b0, ld_ready}, {31'b0, e_ldr});
                if (e_drain) begin
                    chk("drain_addr", mem_addr, q_addr[0]);
                    chk("drain_wd",   mem_wd,   q_data[0]);
                end else begin
                    chk("port_addr", mem_addr, ld_addr);
                    if (!ld_valid) chk("idle_wd", mem_wd, 32'h0);
                end
                if (e_ldr) chk("ld_data", ld_data, e_ldd);
                exp_drain_r = e_drain;
                exp_enq_r   = st_valid && !m_full;
                enq_addr_r  = st_addr;
                enq_data_r  = st_data;
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok       = 1'b0;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (st_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("store_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    task automatic wait_empty();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb_empty) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("empty_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0;

        // Reset values, sampled mid-cycle
        #12;
        chk("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
        chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
        chk("rst_mem_we",   {31'b0, mem_we},   32'd0);
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd",   mem_wd,   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Four stores, loads idle
        do_store(32'h10, 32'h11111111);
        do_store(32'h14, 32'h22222222);
        do_store(32'h18, 32'h33333333);
        do_store(32'h1C, 32'h44444444);
        wait_empty();
        chk("mem_10", mem_word(8'h10), 32'h11111111);
        chk("mem_14", mem_word(8'h14), 32'h22222222);
        chk("mem_18", mem_word(8'h18), 32'h33333333);
        chk("mem_1c", mem_word(8'h1C), 32'h44444444);

        // Forwarding from the youngest of two same-address stores
        ld_valid = 1'b1; ld_addr = 32'h80;
        do_store(32'h20, 32'hAAAA0001);
        do_store(32'h20, 32'hBBBB0002);
        ld_addr = 32'h20;
        @(negedge clk);
        chk("fwd_ready", {31'b0, ld_ready}, 32'd1);
        chk("fwd_data",  ld_data, 32'hBBBB0002);
        chk("fwd_drain", {31'b0, mem_we}, 32'd1);
        chk("fwd_drain_wd", mem_wd, 32'hAAAA0001);
        @(negedge clk);
        chk("fwd_data2", ld_data, 32'hBBBB0002);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        wait_empty();
        chk("mem_20", mem_word(8'h20), 32'hBBBB0002);

        // Partial overlap stalls until the store drains
        ld_valid = 1'b1; ld_addr = 32'h80;
        do_store(32'h30, 32'hDDCCBBAA);
        ld_addr = 32'h32;
        @(negedge clk);
        chk("part_stall", {31'b0, ld_ready}, 32'd0);
        chk("part_drain", {31'b0, mem_we}, 32'd1);
        @(negedge clk);
        chk("part_ready", {31'b0, ld_ready}, 32'd1);
        chk("part_data",  ld_data, 32'h0000DDCC);
        @(posedge clk); #1;
        ld_valid = 1'b0;

        // Fill while an unrelated load stream holds the port
        ld_valid = 1'b1; ld_addr = 32'h80;
        for (int i = 0; i < 4; i++) do_store(32'h60 + 32'(4 * i), 32'h60000000 + 32'(i));
        @(negedge clk);
        chk("full_st_ready", {31'b0, st_ready}, 32'd0);
        chk("full_ld_ready", {31'b0, ld_ready}, 32'd0);
        chk("full_drain",    {31'b0, mem_we},   32'd1);
        chk("full_addr",     mem_addr, 32'h60);
        @(negedge clk);
        chk("stream_ready", {31'b0, ld_ready}, 32'd1);
        chk("stream_we",    {31'b0, mem_we},   32'd0);
        chk("stream_data",  ld_data, 32'h5A5A1234);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        wait_empty();
        for (int i = 0; i < 4; i++) chk("mem_6x", mem_word(8'h60 + 8'(4 * i)), 32'h60000000 + 32'(i));

        // Ten back-to-back stores, pointers wrap
        for (int i = 0; i < 10; i++) do_store(32'h90 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
        wait_empty();
        for (int i = 0; i < 10; i++) chk("mem_wrap", mem_word(8'h90 + 8'(4 * i)), 32'hC0DE0000 + 32'(i));

        // Mid-cycle reset discards pending stores
        ld_valid = 1'b1; ld_addr = 32'h80;
        do_store(32'h40, 32'h12345678);
        do_store(32'h44, 32'h9ABCDEF0);
        @(negedge clk); #1;
        ld_valid = 1'b0; ld_addr = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_sb_empty", {31'b0, sb_empty}, 32'd1);
        chk("mrst_st_ready", {31'b0, st_ready}, 32'd1);
        chk("mrst_mem_we",   {31'b0, mem_we},   32'd0);
        chk("mrst_ld_ready", {31'b0, ld_ready}, 32'd0);
        chk("mrst_mem_addr", mem_addr, 32'd0);
        chk("mrst_mem_wd",   mem_wd,   32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_mem_40", mem_word(8'h40), 32'h0);
        chk("mrst_mem_44", mem_word(8'h44), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
